// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: channel bus of the scanning front-end selector.
//   din/mode/sel/en_mask/hold : requester -> selector
//   dout/ch_idx/dvalid/wrap   : selector -> consumer (all registered)
// SEL_W has to match the selector's derived width, max(1, ceil(log2(N_CH))).
interface mux_scan_n_if #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
);
  logic [N_CH*W-1:0] din;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH-1:0]   en_mask;
  logic              hold;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  ch_idx;
  logic              dvalid;
  logic              wrap;

  modport master (
    output din, mode, sel, en_mask, hold,
    input  dout, ch_idx, dvalid, wrap
  );

  modport slave (
    input  din, mode, sel, en_mask, hold,
    output dout, ch_idx, dvalid, wrap
  );
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel registered multiplexer.
//   mode=0 : manual, sel picks the channel each cycle.
//   mode=1 : round-robin over en_mask channels, DWELL cycles each;
//            hold freezes the scan pointer and dwell counter.
// Ports:
//   cp   clock (rising edge)
//   rst  synchronous active-high reset
//   bus  mux_scan_n_if.slave (din, mode, sel, en_mask, hold in;
//        dout, ch_idx, dvalid, wrap out)
// One cycle latency; every output comes straight from a flop.

// Per-channel slice: gates its data onto the manual and scan AND-OR
// trees when the respective pointer addresses this channel.
module mux_scan_n_lane #(
  parameter int W     = 8,
  parameter int SEL_W = 2,
  parameter int K     = 0
) (
  input  logic [W-1:0]     din,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] p,
  output logic [W-1:0]     man_dat,
  output logic             man_en,
  output logic [W-1:0]     scan_dat,
  output logic             scan_en
);
  logic hit_m, hit_s;

  assign hit_m    = (sel == SEL_W'(K));
  assign hit_s    = (p == SEL_W'(K));
  assign man_dat  = hit_m ? din : '0;
  assign man_en   = hit_m & en;
  assign scan_dat = hit_s ? din : '0;
  assign scan_en  = hit_s & en;
endmodule

module mux_scan_n #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input  logic         cp,
  input  logic         rst,
  mux_scan_n_if.slave  bus
);
  localparam int SEL_W = (N_CH  <= 2) ? 1 : $clog2(N_CH);
  localparam int CNT_W = (DWELL <= 2) ? 1 : $clog2(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  typedef enum logic {S_SCAN, S_EMPTY} st_t;

  st_t              st_q, st_d;
  logic [SEL_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             pend_q, pend_d;   // lap wrapped; flag the next sample
  logic             mode_q;           // mode seen at the previous edge
  logic [W-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             dv_q, dv_d, wr_q, wr_d;

  // lane fan-out
  logic [N_CH-1:0][W-1:0] din_a, man_l, scan_l;
  logic [N_CH-1:0]        man_en_l, scan_en_l;
  logic [W-1:0]           man_dat, scan_dat;
  logic                   man_en, scan_en;

  assign din_a = bus.din;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_scan_n_lane #(.W(W), .SEL_W(SEL_W), .K(k)) u_lane (
      .din      (din_a[k]),
      .en       (bus.en_mask[k]),
      .sel      (bus.sel),
      .p        (p_q),
      .man_dat  (man_l[k]),
      .man_en   (man_en_l[k]),
      .scan_dat (scan_l[k]),
      .scan_en  (scan_en_l[k])
    );
  end

  // Out-of-range sel hits no lane, so the tree yields 0 / not valid.
  always_comb begin
    man_dat  = '0;
    scan_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      man_dat  = man_dat  | man_l[k];
      scan_dat = scan_dat | scan_l[k];
    end
  end
  assign man_en  = |man_en_l;
  assign scan_en = |scan_en_l;

  // Circular search for enabled channels. Iterating from the far end
  // down lets the nearest hit win. nxt_after includes p itself as the
  // last candidate so a lone enabled channel wraps onto itself.
  logic [SEL_W-1:0] nxt_after, first_from;
  always_comb begin
    int j;
    j          = 0;
    nxt_after  = p_q;
    first_from = p_q;
    for (int i = N_CH; i >= 1; i--) begin
      j = (int'(p_q) + i) % N_CH;
      if (bus.en_mask[j]) nxt_after = SEL_W'(j);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = (int'(p_q) + i) % N_CH;
      if (bus.en_mask[j]) first_from = SEL_W'(j);
    end
  end

  // Coming back from manual restarts a full dwell on the retained p.
  assign cnt_eff = mode_q ? cnt_q : '0;

  always_comb begin
    st_d   = st_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    pend_d = 1'b0;
    dout_d = dout_q;
    ch_d   = ch_q;
    dv_d   = 1'b0;
    wr_d   = 1'b0;
    if (!bus.mode) begin
      dout_d = man_dat;
      ch_d   = bus.sel;
      dv_d   = man_en;
    end else if (bus.en_mask == '0) begin
      st_d = S_EMPTY;
    end else if (st_q == S_EMPTY) begin
      // re-entry: pick up at p or the next enabled channel after it
      st_d  = S_SCAN;
      p_d   = first_from;
      cnt_d = '0;
    end else begin
      dout_d = scan_dat;
      ch_d   = p_q;
      dv_d   = scan_en;
      wr_d   = pend_q;
      cnt_d  = cnt_eff;
      if (!bus.hold) begin
        // a channel disabled mid-dwell forfeits its remaining dwell
        if (!scan_en || cnt_eff == LAST) begin
          p_d    = nxt_after;
          cnt_d  = '0;
          pend_d = (nxt_after <= p_q);
        end else begin
          cnt_d = cnt_eff + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      st_q   <= S_SCAN;
      p_q    <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      mode_q <= 1'b0;
      dout_q <= '0;
      ch_q   <= '0;
      dv_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      mode_q <= bus.mode;
      dout_q <= dout_d;
      ch_q   <= ch_d;
      dv_q   <= dv_d;
      wr_q   <= wr_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.ch_idx = ch_q;
  assign bus.dvalid = dv_q;
  assign bus.wrap   = wr_q;
endmodule
